// File: rtl/uart_rx_oversample_pkg.sv
// Shared types and defaults for the oversampling 8N1 UART receiver.
package uart_rx_oversample_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam int OVS_DEFAULT       = 16;
    localparam int DATA_BITS_DEFAULT = 8;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_oversample_if.sv
// Receive-byte handshake between the UART receiver (master) and the RX unloader (slave).
interface uart_rx_oversample_if
    import uart_rx_oversample_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEFAULT
);
    logic                 uld_rx_data;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_empty;
    logic                 frame_err;
    logic                 overrun;

    modport master (input uld_rx_data, output rx_data, rx_empty, frame_err, overrun);
    modport slave  (output uld_rx_data, input rx_data, rx_empty, frame_err, overrun);
endinterface

// File: rtl/uart_rx_oversample_sync.sv
// Two-flop synchronizer for the raw serial line plus a 3-sample majority voter.
module uart_rx_oversample_sync
    import uart_rx_oversample_pkg::*;
(
    input  logic ct_rxclk,
    input  logic reset,
    input  logic rx_in,
    output logic sync,
    output logic maj
);
    logic       sync_p0;
    logic       sync_p1;
    logic [2:0] smp_p2;

    // Idle line is high, so everything resets to ones to avoid a fake start bit.
    always_ff @(posedge ct_rxclk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            smp_p2  <= 3'b111;
        end else begin
            sync_p0 <= rx_in;
            sync_p1 <= sync_p0;
            smp_p2  <= {smp_p2[1:0], sync_p1};
        end
    end

    assign sync = sync_p1;
    assign maj  = maj3(smp_p2);

endmodule

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver: start/data/stop FSM on oversampled line, one-byte holding register,
// sticky framing and overrun flags cleared by the unloader's uld_rx_data pulse.
module uart_rx_oversample
    import uart_rx_oversample_pkg::*;
#(
    parameter int OVS       = OVS_DEFAULT,
    parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
    input  logic                 ct_rxclk,
    input  logic                 reset,
    input  logic                 rx_enable,
    input  logic                 rx_in,
    uart_rx_oversample_if.master bus
);
    localparam int TW = $clog2(OVS);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_HALF = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 line;
    logic                 maj;
    rx_state_t            state, state_next;
    logic [TW-1:0]        tick_cnt, tick_next;
    logic [BW-1:0]        bit_cnt, bit_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic                 armed;
    logic                 start;
    logic                 commit;
    logic                 ferr;
    logic [DATA_BITS-1:0] hold_data;
    logic                 empty;
    logic                 ferr_flag;
    logic                 ovr_flag;

    uart_rx_oversample_sync u_sync (
        .ct_rxclk (ct_rxclk),
        .reset    (reset),
        .rx_in    (rx_in),
        .sync     (line),
        .maj      (maj)
    );

    always_comb begin
        state_next = state;
        tick_next  = tick_cnt + 1'b1;
        bit_next   = bit_cnt;
        shreg_next = shreg;
        start      = 1'b0;
        commit     = 1'b0;
        ferr       = 1'b0;
        case (state)
            RX_IDLE: begin
                tick_next = '0;
                // armed blocks retriggering on a line that stayed low after a break
                if (!line && armed) begin
                    state_next = RX_START;
                    start      = 1'b1;
                end
            end
            RX_START: begin
                if (tick_cnt == TICK_HALF) begin
                    tick_next  = '0;
                    bit_next   = '0;
                    state_next = maj ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (tick_cnt == TICK_LAST) begin
                    tick_next  = '0;
                    shreg_next = {maj, shreg[DATA_BITS-1:1]};
                    bit_next   = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (tick_cnt == TICK_LAST) begin
                    tick_next  = '0;
                    state_next = RX_IDLE;
                    commit     = maj;
                    ferr       = !maj;
                end
            end
            default: state_next = RX_IDLE;
        endcase
        if (!rx_enable) begin
            state_next = RX_IDLE;
            tick_next  = '0;
            shreg_next = shreg;
            start      = 1'b0;
            commit     = 1'b0;
            ferr       = 1'b0;
        end
    end

    always_ff @(posedge ct_rxclk or negedge reset) begin
        if (!reset) begin
            state     <= RX_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            armed     <= 1'b1;
            hold_data <= '0;
            empty     <= 1'b1;
            ferr_flag <= 1'b0;
            ovr_flag  <= 1'b0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_next;
            bit_cnt  <= bit_next;
            shreg    <= shreg_next;
            if (start)
                armed <= 1'b0;
            else if (state == RX_IDLE && line)
                armed <= 1'b1;
            // A commit outranks a simultaneous unload: the new byte is unread.
            if (commit) begin
                hold_data <= shreg;
                empty     <= 1'b0;
            end else if (bus.uld_rx_data) begin
                empty <= 1'b1;
            end
            if (commit && !empty && !bus.uld_rx_data)
                ovr_flag <= 1'b1;
            else if (bus.uld_rx_data)
                ovr_flag <= 1'b0;
            if (ferr)
                ferr_flag <= 1'b1;
            else if (bus.uld_rx_data)
                ferr_flag <= 1'b0;
        end
    end

    assign bus.rx_data   = hold_data;
    assign bus.rx_empty  = empty;
    assign bus.frame_err = ferr_flag;
    assign bus.overrun   = ovr_flag;

endmodule
